prt_int_rcfg_seq: RTL

//  Local-bus reconfig sequencer driving N Intel Avalon-MM transceiver reconfig ports. It adds

---
 rtl/prt_int_rcfg_pkg.sv | 48 ++++
 rtl/prt_int_rcfg_seq_fsm.sv | 154 +++++++++++++++
 rtl/prt_int_rcfg_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prt_int_rcfg_pkg.sv
`default_nettype none
//==========================================================================
// prt_int_rcfg_pkg -- shared register map, bit positions, states (rev 1.0)
//==========================================================================
package prt_int_rcfg_pkg;

   localparam logic [3:0] REG_CTL   = 4'd0;
   localparam logic [3:0] REG_STA   = 4'd1;
   localparam logic [3:0] REG_ADR   = 4'd2;
   localparam logic [3:0] REG_PMASK = 4'd3;
   localparam logic [3:0] REG_WDAT  = 4'd4;
   localparam logic [3:0] REG_WMSK  = 4'd5;
   localparam logic [3:0] REG_RDAT  = 4'd6;

   localparam int CTL_WR    = 0;
   localparam int CTL_RD    = 1;
   localparam int CTL_RMW   = 2;
   localparam int CTL_ABORT = 3;

   localparam int STA_BUSY     = 0;
   localparam int STA_RDY      = 1;
   localparam int STA_TO_ERR   = 2;
   localparam int STA_CMD_DROP = 3;
   localparam int STA_ERR_LSB  = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEL  = 3'd1,
      ST_RD   = 3'd2,
      ST_MRG  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      CMD_WR  = 2'd0,
      CMD_RD  = 2'd1,
      CMD_RMW = 2'd2
   } cmd_e;

   function automatic logic [31:0] rmw_merge(input logic [31:0] rdat,
                                             input logic [31:0] wdat,
                                             input logic [31:0] wmsk);
      return (rdat & ~wmsk) | (wdat & wmsk);
   endfunction

endpackage
`default_nettype wire

// File: rtl/prt_int_rcfg_seq_fsm.sv
`default_nettype none
//==========================================================================
// prt_int_rcfg_seq_fsm -- port walk, Avalon strobes, timeout, RMW (rev 1.0)
//==========================================================================
module prt_int_rcfg_seq_fsm
   import prt_int_rcfg_pkg::*;
#(
   parameter int P_RCFG_PORTS = 4,
   parameter int P_RCFG_ADR   = 10,
   parameter int P_RCFG_DAT   = 32,
   parameter int P_TO_CYCLES  = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [1:0]                         cmd,
   input  logic                               abort,
   input  logic [P_RCFG_ADR-1:0]              adr_in,
   input  logic [P_RCFG_PORTS-1:0]            pmask_in,
   input  logic [P_RCFG_DAT-1:0]              wdat_in,
   input  logic [P_RCFG_DAT-1:0]              wmsk_in,
   output logic                               busy,
   output logic                               done_ok,
   output logic                               to_hit,
   output logic [3:0]                         err_port,
   output logic [P_RCFG_DAT-1:0]              rd_cap,
   output logic [P_RCFG_PORTS*P_RCFG_ADR-1:0] rcfg_adr,
   output logic [P_RCFG_PORTS-1:0]            rcfg_wr,
   output logic [P_RCFG_PORTS-1:0]            rcfg_rd,
   output logic [P_RCFG_PORTS*P_RCFG_DAT-1:0] rcfg_wdat,
   input  logic [P_RCFG_PORTS*P_RCFG_DAT-1:0] rcfg_rdat,
   input  logic [P_RCFG_PORTS-1:0]            rcfg_wait
);

   localparam int             CW     = $clog2(P_TO_CYCLES);
   localparam logic [CW-1:0]  TO_MAX = CW'(P_TO_CYCLES - 1);

   state_e                  state, state_nxt;
   cmd_e                    cmd_q;
   logic [P_RCFG_ADR-1:0]   adr_q;
   logic [P_RCFG_DAT-1:0]   wdat_q, wmsk_q, dat_q, cap_q;
   logic [P_RCFG_PORTS-1:0] rem_q, sel_q, low;
   logic [3:0]              cur_q, low_idx;
   logic [CW-1:0]           cnt_q;
   logic                    got_rd_q, fail_q;
   logic                    stb, wait_hit, cmpl;
   logic [P_RCFG_DAT-1:0]   rdat_sel;

   assign low      = rem_q & (~rem_q + P_RCFG_PORTS'(1));
   assign wait_hit = |(rcfg_wait & sel_q);
   assign stb      = (state == ST_RD) || (state == ST_WR);
   assign cmpl     = stb && !wait_hit;
   assign to_hit   = stb && wait_hit && !abort && (cnt_q == TO_MAX);

   always_comb begin
      low_idx  = '0;
      rdat_sel = '0;
      for (int i = P_RCFG_PORTS - 1; i >= 0; i--) begin
         if (rem_q[i]) low_idx = 4'(i);
      end
      for (int i = 0; i < P_RCFG_PORTS; i++) begin
         if (sel_q[i]) rdat_sel = rcfg_rdat[i*P_RCFG_DAT +: P_RCFG_DAT];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_SEL;
         ST_SEL: begin
            if (abort || rem_q == '0)  state_nxt = ST_DONE;
            else if (cmd_q == CMD_WR)  state_nxt = ST_WR;
            else                       state_nxt = ST_RD;
         end
         ST_RD: begin
            if (abort)     state_nxt = ST_DONE;
            else if (cmpl) state_nxt = (cmd_q == CMD_RMW) ? ST_MRG : ST_DONE;
            else if (to_hit) state_nxt = ST_DONE;
         end
         ST_MRG: state_nxt = abort ? ST_DONE : ST_WR;
         ST_WR: begin
            if (abort)       state_nxt = ST_DONE;
            else if (cmpl)   state_nxt = ST_SEL;
            else if (to_hit) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q    <= CMD_WR;
         adr_q    <= '0;
         wdat_q   <= '0;
         wmsk_q   <= '0;
         dat_q    <= '0;
         cap_q    <= '0;
         rem_q    <= '0;
         sel_q    <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         got_rd_q <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) begin
            cmd_q    <= cmd_e'(cmd);
            adr_q    <= adr_in;
            wdat_q   <= wdat_in;
            wmsk_q   <= wmsk_in;
            dat_q    <= wdat_in;
            rem_q    <= pmask_in;
            sel_q    <= '0;
            got_rd_q <= 1'b0;
            fail_q   <= 1'b0;
         end
         if (state == ST_SEL) begin
            sel_q <= low;
            cur_q <= low_idx;
         end
         cnt_q <= (stb && wait_hit) ? cnt_q + CW'(1) : '0;
         if (cmpl && !abort) begin
            rem_q <= rem_q & ~sel_q;
            if (state == ST_RD) begin
               cap_q    <= rdat_sel;
               got_rd_q <= 1'b1;
            end
         end
         if (state == ST_MRG && !abort)
            dat_q <= P_RCFG_DAT'(rmw_merge(32'(cap_q), 32'(wdat_q), 32'(wmsk_q)));
         if (to_hit || (abort && state != ST_IDLE)) fail_q <= 1'b1;
      end
   end

   assign busy     = (state != ST_IDLE);
   assign done_ok  = (state == ST_DONE) && got_rd_q && !fail_q && !abort;
   assign err_port = cur_q;
   assign rd_cap   = cap_q;

   // Strobes decode straight from registered state, so reset clears them immediately.
   for (genvar i = 0; i < P_RCFG_PORTS; i++) begin : g_port
      assign rcfg_adr[i*P_RCFG_ADR +: P_RCFG_ADR]  = adr_q;
      assign rcfg_wdat[i*P_RCFG_DAT +: P_RCFG_DAT] = dat_q;
      assign rcfg_wr[i] = (state == ST_WR) && sel_q[i];
      assign rcfg_rd[i] = (state == ST_RD) && sel_q[i];
   end

endmodule
`default_nettype wire

// File: rtl/prt_int_rcfg_seq.sv
`default_nettype none
//==========================================================================
// prt_int_rcfg_seq -- local-bus reconfig sequencer, register file top (rev 1.0)
//==========================================================================
module prt_int_rcfg_seq
   import prt_int_rcfg_pkg::*;
#(
   parameter int P_RCFG_PORTS = 4,
   parameter int P_RCFG_ADR   = 10,
   parameter int P_RCFG_DAT   = 32,
   parameter int P_TO_CYCLES  = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [3:0]                         lb_adr,
   input  logic                               lb_wr,
   input  logic                               lb_rd,
   input  logic [31:0]                        lb_din,
   output logic [31:0]                        lb_dout,
   output logic                               lb_vld,
   output logic [P_RCFG_PORTS*P_RCFG_ADR-1:0] rcfg_adr,
   output logic [P_RCFG_PORTS-1:0]            rcfg_wr,
   output logic [P_RCFG_PORTS-1:0]            rcfg_rd,
   output logic [P_RCFG_PORTS*P_RCFG_DAT-1:0] rcfg_wdat,
   input  logic [P_RCFG_PORTS*P_RCFG_DAT-1:0] rcfg_rdat,
   input  logic [P_RCFG_PORTS-1:0]            rcfg_wait
);

   logic [3:0]              adr_q;
   logic                    wr_q, rd_q;
   logic [31:0]             din_q;
   logic [P_RCFG_ADR-1:0]   adr_sh;
   logic [P_RCFG_PORTS-1:0] pmask_sh;
   logic [P_RCFG_DAT-1:0]   wdat_sh, wmsk_sh, rdat_q, rd_cap;
   logic                    rdy_q, to_err_q, drop_q;
   logic [3:0]              err_q, fsm_err;
   logic                    busy, done_ok, to_hit;
   logic                    ctl_wr, sta_wr, any_cmd, multi_cmd, start, drop, abort;
   logic [2:0]              cmd_bits;
   logic [1:0]              cmd;
   logic [31:0]             sta, rd_data;

   assign ctl_wr    = wr_q && (adr_q == REG_CTL);
   assign sta_wr    = wr_q && (adr_q == REG_STA);
   assign cmd_bits  = din_q[CTL_RMW:CTL_WR];
   assign any_cmd   = |cmd_bits;
   assign multi_cmd = (cmd_bits[0] & cmd_bits[1]) | (cmd_bits[0] & cmd_bits[2]) |
                      (cmd_bits[1] & cmd_bits[2]);
   assign start     = ctl_wr && any_cmd && !multi_cmd && !busy;
   assign drop      = ctl_wr && any_cmd && (multi_cmd || busy);
   assign abort     = ctl_wr && din_q[CTL_ABORT] && busy;
   assign cmd       = cmd_bits[CTL_WR] ? CMD_WR : (cmd_bits[CTL_RD] ? CMD_RD : CMD_RMW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q    <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         din_q    <= '0;
         adr_sh   <= '0;
         pmask_sh <= '0;
         wdat_sh  <= '0;
         wmsk_sh  <= '0;
         rdat_q   <= '0;
         rdy_q    <= 1'b0;
         to_err_q <= 1'b0;
         drop_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         adr_q <= lb_adr;
         wr_q  <= lb_wr;
         rd_q  <= lb_rd;
         din_q <= lb_din;
         if (wr_q) begin
            case (adr_q)
               REG_ADR:   adr_sh   <= din_q[P_RCFG_ADR-1:0];
               REG_PMASK: pmask_sh <= din_q[P_RCFG_PORTS-1:0];
               REG_WDAT:  wdat_sh  <= din_q[P_RCFG_DAT-1:0];
               REG_WMSK:  wmsk_sh  <= din_q[P_RCFG_DAT-1:0];
               default: ;
            endcase
         end
         // Hardware set takes priority over a same-cycle W1C.
         if (done_ok)                        rdy_q <= 1'b1;
         else if (sta_wr && din_q[STA_RDY])  rdy_q <= 1'b0;
         if (to_hit)                            to_err_q <= 1'b1;
         else if (sta_wr && din_q[STA_TO_ERR])  to_err_q <= 1'b0;
         if (drop)                                drop_q <= 1'b1;
         else if (sta_wr && din_q[STA_CMD_DROP])  drop_q <= 1'b0;
         if (to_hit)  err_q  <= fsm_err;
         if (done_ok) rdat_q <= rd_cap;
      end
   end

   always_comb begin
      sta                              = '0;
      sta[STA_BUSY]                    = busy;
      sta[STA_RDY]                     = rdy_q;
      sta[STA_TO_ERR]                  = to_err_q;
      sta[STA_CMD_DROP]                = drop_q;
      sta[STA_ERR_LSB+3:STA_ERR_LSB]   = err_q;
   end

   always_comb begin
      rd_data = '0;
      case (adr_q)
         REG_STA:   rd_data = sta;
         REG_ADR:   rd_data = 32'(adr_sh);
         REG_PMASK: rd_data = 32'(pmask_sh);
         REG_WDAT:  rd_data = 32'(wdat_sh);
         REG_WMSK:  rd_data = 32'(wmsk_sh);
         REG_RDAT:  rd_data = 32'(rdat_q);
         default:   rd_data = '0;
      endcase
   end

   assign lb_vld  = rd_q;
   assign lb_dout = rd_q ? rd_data : '0;

   prt_int_rcfg_seq_fsm #(
      .P_RCFG_PORTS (P_RCFG_PORTS),
      .P_RCFG_ADR   (P_RCFG_ADR),
      .P_RCFG_DAT   (P_RCFG_DAT),
      .P_TO_CYCLES  (P_TO_CYCLES)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cmd       (cmd),
      .abort     (abort),
      .adr_in    (adr_sh),
      .pmask_in  (pmask_sh),
      .wdat_in   (wdat_sh),
      .wmsk_in   (wmsk_sh),
      .busy      (busy),
      .done_ok   (done_ok),
      .to_hit    (to_hit),
      .err_port  (fsm_err),
      .rd_cap    (rd_cap),
      .rcfg_adr  (rcfg_adr),
      .rcfg_wr   (rcfg_wr),
      .rcfg_rd   (rcfg_rd),
      .rcfg_wdat (rcfg_wdat),
      .rcfg_rdat (rcfg_rdat),
      .rcfg_wait (rcfg_wait)
   );

endmodule
`default_nettype wire
